// File: rtl/universal_register.sv
// universal_register: WIDTH-bit storage element with hold, parallel load,
// logical shift, rotate and up/down count modes. Q and Qn come from one
// stored vector, so the complement always tracks Q exactly. The serial taps
// are plain wires off Q, so several registers can be chained by connecting
// SerOutL of one register to SerInR of the next.
module universal_register #(
    parameter int              WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Preset,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerInL,
    input  logic             SerInR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             SerOutL,
    output logic             SerOutR,
    output logic             Tc
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_UP    = 3'b110;
    localparam logic [2:0] MODE_DOWN  = 3'b111;

    logic [WIDTH-1:0] q_next;
    logic             count_full;
    logic             count_zero;

    // Next-value selection. Each mode reads only the inputs it needs, so an
    // undriven D or serial input cannot reach Q in any other mode.
    always_comb begin
        q_next = Q;
        if (!Preset) begin
            q_next = PRESET_VALUE;
        end else if (En) begin
            case (Mode)
                MODE_HOLD: q_next = Q;
                MODE_LOAD: q_next = D;
                MODE_SHL:  q_next = {Q[WIDTH-2:0], SerInR};
                MODE_SHR:  q_next = {SerInL, Q[WIDTH-1:1]};
                MODE_ROL:  q_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
                MODE_ROR:  q_next = {Q[0], Q[WIDTH-1:1]};
                MODE_UP:   q_next = Q + 1'b1;
                MODE_DOWN: q_next = Q - 1'b1;
                default:   q_next = Q;
            endcase
        end
    end

    // Storage: asynchronous reset wins over everything; otherwise take the
    // selected next value on the rising edge.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Q <= RESET_VALUE;
        end else begin
            Q <= q_next;
        end
    end

    // Derived outputs: complement and serial taps are pure functions of Q.
    assign Qn      = ~Q;
    assign SerOutL = Q[WIDTH-1];
    assign SerOutR = Q[0];

    // Terminal count flags the edge on which the counter is about to wrap.
    // Preset is deliberately ignored; a consumer that cares gates it itself.
    assign count_full = &Q;
    assign count_zero = ~|Q;
    assign Tc = Reset & En &
                (((Mode == MODE_UP)   & count_full) |
                 ((Mode == MODE_DOWN) & count_zero));

endmodule

// File: tb/tb_universal_register.sv
// Bench for universal_register (WIDTH=8, reset 0x00, preset 0xFF):
// a vector table walking the mode set, hand sequences for asynchronous
// reset, and a randomized run against an arithmetic reference model.
module tb_universal_register;

    logic       Clock;
    logic       Reset;
    logic       Preset;
    logic       En;
    logic [2:0] Mode;
    logic [7:0] D;
    logic       SerInL;
    logic       SerInR;
    logic [7:0] Q;
    logic [7:0] Qn;
    logic       SerOutL;
    logic       SerOutR;
    logic       Tc;

    int checks   = 0;
    int failures = 0;

    universal_register #(
        .WIDTH        (8),
        .RESET_VALUE  (8'h00),
        .PRESET_VALUE (8'hFF)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Preset  (Preset),
        .En      (En),
        .Mode    (Mode),
        .D       (D),
        .SerInL  (SerInL),
        .SerInR  (SerInR),
        .Q       (Q),
        .Qn      (Qn),
        .SerOutL (SerOutL),
        .SerOutR (SerOutR),
        .Tc      (Tc)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic       preset;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sil;
        logic       sir;
        logic       exp_tc;   // Tc before the edge
        logic [7:0] exp_q;    // Q after the edge
    } vec_t;

    vec_t tbl[32];
    int   n_vec = 0;

    function automatic vec_t mk(logic p, logic e, logic [2:0] m, logic [7:0] d,
                                logic sil, logic sir, logic tc, logic [7:0] q);
        vec_t v;
        v.preset = p; v.en = e; v.mode = m; v.d = d;
        v.sil = sil; v.sir = sir; v.exp_tc = tc; v.exp_q = q;
        return v;
    endfunction

    task automatic add(vec_t v);
        tbl[n_vec] = v;
        n_vec++;
    endtask

    task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_outputs(string name, logic [7:0] exp_q);
        check8({name, "_q"},  Q,  exp_q);
        check8({name, "_qn"}, Qn, ~exp_q);
        check1({name, "_sol"}, SerOutL, exp_q[7]);
        check1({name, "_sor"}, SerOutR, exp_q[0]);
    endtask

    task automatic drive(logic p, logic e, logic [2:0] m, logic [7:0] d,
                         logic sil, logic sir);
        Preset = p; En = e; Mode = m; D = d; SerInL = sil; SerInR = sir;
    endtask

    // Reference model: the operations written as plain integer arithmetic.
    function automatic int model_next(int q, logic p, logic e, int m, int d,
                                      int sil, int sir);
        if (!p) return 255;
        if (!e) return q;
        case (m)
            0: return q;
            1: return d;
            2: return (q * 2 + sir) % 256;
            3: return q / 2 + sil * 128;
            4: return (q * 2) % 256 + q / 128;
            5: return q / 2 + (q % 2) * 128;
            6: return (q + 1) % 256;
            default: return (q + 255) % 256;
        endcase
    endfunction

    function automatic logic model_tc(int q, logic e, int m);
        return e && ((m == 6 && q == 255) || (m == 7 && q == 0));
    endfunction

    initial begin
        int   mq;
        logic x1;
        logic [7:0] x8;
        x1 = 1'bx;
        x8 = 8'hxx;

        // Reset state, held across no edge
        Reset = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
        #2;
        check_outputs("reset", 8'h00);
        check1("reset_tc", Tc, 1'b0);
        #10 Reset = 1'b1;  // t=12, between edges
        step();
        check_outputs("reset_release", 8'h00);

        // Table: sequential walk starting from Q=0x00. Unused serial/data
        // inputs are X to show they never reach Q.
        add(mk(1, 1, 3'b001, 8'h81, x1, x1, 0, 8'h81));
        add(mk(1, 1, 3'b010, x8,    x1, 1,  0, 8'h03));
        add(mk(1, 1, 3'b010, x8,    x1, 1,  0, 8'h07));
        add(mk(1, 1, 3'b011, x8,    0,  x1, 0, 8'h03));
        add(mk(1, 1, 3'b001, 8'h81, x1, x1, 0, 8'h81));
        add(mk(1, 1, 3'b100, x8,    x1, x1, 0, 8'h03));
        add(mk(1, 1, 3'b101, x8,    x1, x1, 0, 8'h81));
        add(mk(1, 1, 3'b101, x8,    x1, x1, 0, 8'hC0));
        add(mk(1, 1, 3'b001, 8'hFE, x1, x1, 0, 8'hFE));
        add(mk(1, 1, 3'b110, x8,    x1, x1, 0, 8'hFF));
        add(mk(1, 1, 3'b110, x8,    x1, x1, 1, 8'h00));
        add(mk(1, 1, 3'b111, x8,    x1, x1, 1, 8'hFF));
        add(mk(1, 1, 3'b111, x8,    x1, x1, 0, 8'hFE));
        add(mk(1, 1, 3'b001, 8'h10, x1, x1, 0, 8'h10));
        add(mk(0, 1, 3'b110, 8'h55, 0,  0,  0, 8'hFF));
        add(mk(1, 0, 3'b110, 8'h55, 0,  0,  0, 8'hFF));
        add(mk(1, 0, 3'b110, 8'h55, 0,  0,  0, 8'hFF));
        add(mk(1, 0, 3'b110, 8'h55, 0,  0,  0, 8'hFF));
        add(mk(1, 1, 3'b001, 8'h00, x1, x1, 0, 8'h00));
        add(mk(0, 1, 3'b111, 8'h55, 0,  0,  1, 8'hFF));  // Tc ignores Preset
        add(mk(1, 1, 3'b000, x8,    x1, x1, 0, 8'hFF));
        add(mk(1, 1, 3'b010, x8,    x1, 0,  0, 8'hFE));
        add(mk(1, 1, 3'b011, x8,    1,  x1, 0, 8'hFF));
        add(mk(1, 0, 3'b001, 8'h33, 0,  0,  0, 8'hFF));

        for (int i = 0; i < n_vec; i++) begin
            drive(tbl[i].preset, tbl[i].en, tbl[i].mode, tbl[i].d,
                  tbl[i].sil, tbl[i].sir);
            #1;
            check1($sformatf("vec%0d_tc", i), Tc, tbl[i].exp_tc);
            step();
            check_outputs($sformatf("vec%0d", i), tbl[i].exp_q);
        end

        // SerOutL before a shift-left edge is the bit that leaves Q
        drive(1, 1, 3'b001, 8'h81, 0, 0);
        step();
        drive(1, 1, 3'b010, 8'h00, 0, 1);
        #1;
        check1("shl_leaving_bit", SerOutL, 1'b1);
        step();
        check_outputs("shl_after", 8'h03);

        // Asynchronous reset mid-cycle from 0x5A, Tc gated while in reset
        drive(1, 1, 3'b001, 8'h5A, 0, 0);
        step();
        drive(1, 1, 3'b111, 8'h00, 0, 0);
        #2;
        Reset = 1'b0;
        #1;
        check_outputs("async_rst", 8'h00);
        check1("async_rst_tc", Tc, 1'b0);
        step();
        check_outputs("rst_held_edge", 8'h00);
        #4 Reset = 1'b1;
        drive(1, 1, 3'b001, 8'h3C, 0, 0);
        step();
        check_outputs("load_after_rst", 8'h3C);

        // Reset during a count-up run at 0x7F
        drive(1, 1, 3'b001, 8'h7E, 0, 0);
        step();
        drive(1, 1, 3'b110, 8'h00, 0, 0);
        step();
        check_outputs("count_7f", 8'h7F);
        #2 Reset = 1'b0;
        #1;
        check_outputs("count_rst", 8'h00);
        check1("count_rst_tc", Tc, 1'b0);
        #3 Reset = 1'b1;  // released after the falling edge, before the next rise
        step();
        check_outputs("count_first", 8'h01);

        // Randomized run against the reference model
        mq = 1;
        for (int i = 0; i < 400; i++) begin
            logic p, e, sil, sir;
            int   m, d;
            p   = ($urandom_range(0, 15) != 0);
            e   = ($urandom_range(0, 5) != 0);
            m   = $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0: d = 0;
                1: d = 255;
                default: d = $urandom_range(0, 255);
            endcase
            sil = 1'($urandom_range(0, 1));
            sir = 1'($urandom_range(0, 1));
            drive(p, e, 3'(m), 8'(d), sil, sir);
            #1;
            check1($sformatf("rnd%0d_tc", i), Tc, model_tc(mq, e, m));
            mq = model_next(mq, p, e, m, d, int'(sil), int'(sir));
            step();
            check8($sformatf("rnd%0d_q", i), Q, 8'(mq));
            check8($sformatf("rnd%0d_qn", i), Qn, ~8'(mq));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
